data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Data-memory side of the computational unit's dm/i/data_bus interface.
// - Answers reads and writes issued by the computational unit and its decoder, inserting WAIT_CYCLES wait states.
// - During wait states it drives a stall to the program sequencer; when the access is done it presents read data on dm.
// - Sits between the instruction decoder/computational unit and the sequencer in the multi-clock ROM processor.
// PARAMETERS
// - DATA_W       4  width of a memory word, wr_data and dm
// - ADDR_W       4  address width; depth = 2**ADDR_W words
// - WAIT_CYCLES  2  wait states per access, 0..15; 0 gives a single-cycle stall
// PORTS
// - clk       in   1       single system clock, rising edge
// - reset_n   in   1       asynchronous, active-low reset
// - addr      in   ADDR_W  access address (computational unit register i)
// - wr_data   in   DATA_W  write data (computational unit data_bus)
// - wr_req    in   1       write request (decoder reg_en[7])
// - rd_req    in   1       read request (decoder: source_sel==7 cycle)
// - dm        out  DATA_W  read data to the computational unit
// - dm_valid  out  1       one-cycle pulse: dm updated this cycle
// - stall     out  1       hold sequencer/PC while an access is in progress
// - collision out  1       one-cycle pulse: wr_req and rd_req both seen in IDLE
// - req_err   out  1       sticky: request arrived while state != IDLE
// BEHAVIOUR
// Reset (reset_n low, asynchronous):
// - state=IDLE, wait counter=0.
// - Every memory word=0, dm=0.
// - dm_valid, stall, collision and req_err all 0.
// - Reset release is not synchronised inside this block; the system provides that.
// FSM IDLE -> WAIT -> RESP -> IDLE:
// - IDLE: if (wr_req|rd_req), capture addr, wr_data and op.
// - IDLE: if WAIT_CYCLES>0, go to WAIT with count=WAIT_CYCLES-1; otherwise go to RESP.
// - WAIT: decrement count each cycle; at count==0, perform the access and go to RESP.
// - RESP: lasts one cycle, then IDLE. A new request is accepted in the very next IDLE cycle.
// Access:
// - A write commits mem[addr_q]<=data_q on the edge that enters RESP.
// - A read loads dm<=mem[addr_q] on the same edge, and dm_valid=1 in RESP.
// - dm holds its value until the next read completes; writes never change dm.
// - A read of an address written by the previous access returns the new value.
// Timing, for a request sampled in IDLE at cycle T:
// - stall=1 combinationally in cycle T and stays 1 through T+WAIT_CYCLES; it is 0 in RESP.
// - dm_valid=1 at cycle T+WAIT_CYCLES+1.
// - Total occupancy is WAIT_CYCLES+2 cycles, including RESP.
// Simultaneous events:
// - wr_req and rd_req together in IDLE: the write wins and the read is dropped.
// - In that case collision pulses for one cycle, in cycle T+1.
// - Any request while in WAIT or RESP is ignored (no capture, no memory change) and sets req_err.
// - req_err stays set until reset.
// Reset in mid-operation:
// - An access still in WAIT is abandoned; the memory is cleared anyway.
// - stall deasserts immediately (asynchronously).
// Address and width:
// - addr is used modulo 2**ADDR_W; no bounds error exists.
// - Stored data is exactly DATA_W bits; there is no arithmetic on it.
// - stall is the only combinational output: stall = (state==IDLE & (wr_req|rd_req)) | (state==WAIT).
// TESTING
// 1. Reset: hold reset_n=0 mid-run -> dm=0, dm_valid=0, stall=0, req_err=0; a read of every address returns 0.
// 2. W=2: write 0xA to addr 3 at T, then read addr 3 -> write: stall high T..T+2;
//    read: stall high for 3 cycles, dm=0xA and dm_valid=1 exactly 3 cycles after the read request.
// 3. W=0: back-to-back write 0x5 to addr 15, then read addr 15 -> each stall lasts 1 cycle; dm=0x5 at T+1 of the read.
// 4. Address wrap: write 0x7 to addr 15 and 0x1 to addr 0, then read both -> 0x7 and 0x1; no other address changes.
// 5. Collision: wr_req=rd_req=1, addr 2, data 0xC -> collision pulse at T+1; mem[2]=0xC; dm unchanged; no dm_valid.
// 6. Protocol/reset: raise rd_req during WAIT -> req_err=1 and it stays set;
//    pull reset_n low in WAIT of a write to addr 4 with 0x9 -> mem[4]=0, stall=0 at once.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the computational unit and
// the data memory responder; master issues requests, slave answers them.
interface data_mem_responder_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_req;
  logic              rd_req;
  logic [DATA_W-1:0] dm;
  logic              dm_valid;
  logic              stall;
  logic              collision;
  logic              req_err;

  modport master (
    output addr, wr_data, wr_req, rd_req,
    input  dm, dm_valid, stall, collision, req_err
  );

  modport slave (
    input  addr, wr_data, wr_req, rd_req,
    output dm, dm_valid, stall, collision, req_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory with WAIT_CYCLES wait states per access; stalls the sequencer.
// Ports: clk, reset_n (async low), bus (slave: req in, dm/status out).
module data_mem_responder #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT =
    NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dm_q;
  logic              dm_valid_q;
  logic              coll_q;
  logic              err_q;

  logic              req;
  logic              cap;
  logic              go;
  logic              go_wr;
  logic [ADDR_W-1:0] go_addr;
  logic [DATA_W-1:0] go_data;

  assign req = bus.wr_req | bus.rd_req;

  // With no wait states the access happens straight from the bus
  // inputs on the edge leaving IDLE; otherwise from the captured copy.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    go      = 1'b0;
    go_wr   = wr_q;
    go_addr = addr_q;
    go_data = data_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          cap = 1'b1;
          if (NO_WAIT) begin
            state_n = RESP;
            go      = 1'b1;
            go_wr   = bus.wr_req;
            go_addr = bus.addr;
            go_data = bus.wr_data;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
          go      = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      dm_q       <= '0;
      dm_valid_q <= 1'b0;
      coll_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dm_valid_q <= go & ~go_wr;
      coll_q     <= cap & bus.wr_req & bus.rd_req;
      err_q      <= err_q | ((state != IDLE) & req);
      if (cap) begin
        addr_q <= bus.addr;
        data_q <= bus.wr_data;
        wr_q   <= bus.wr_req;
      end
      if (go & ~go_wr) begin
        dm_q <= mem[go_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (go & go_wr) begin
      mem[go_addr] <= go_data;
    end
  end

  assign bus.stall     = ((state == IDLE) & req) | (state == WAIT);
  assign bus.dm        = dm_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.collision = coll_q;
  assign bus.req_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
// checked against an array model of memory, dm and the sticky error flag.
module tb_data_mem_responder;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_W(4), .ADDR_W(4)) b2 ();
  data_mem_responder_if #(.DATA_W(4), .ADDR_W(4)) b0 ();

  data_mem_responder #(
    .DATA_W(4), .ADDR_W(4), .WAIT_CYCLES(W)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2)
  );

  data_mem_responder #(
    .DATA_W(4), .ADDR_W(4), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m2 [16];
  logic [3:0] m0 [16];
  logic [3:0] dm2, dm0;
  bit         err2, err0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m2[i] = 4'h0;
      m0[i] = 4'h0;
    end
    dm2  = 4'h0;
    dm0  = 4'h0;
    err2 = 1'b0;
    err0 = 1'b0;
  endtask

  // One full access on the W=2 instance, checking every cycle.
  task automatic acc2(input bit wr, input bit rd,
                      input logic [3:0] a, input logic [3:0] d);
    b2.wr_req  = wr;
    b2.rd_req  = rd;
    b2.addr    = a;
    b2.wr_data = d;
    #3;
    chk("w2_stall_req", b2.stall, 1);
    @(posedge clk); #1;
    b2.wr_req  = 1'b0;
    b2.rd_req  = 1'b0;
    b2.addr    = 4'($urandom);
    b2.wr_data = 4'($urandom);
    if (wr) m2[a] = d;
    else    dm2 = m2[a];
    for (int k = 1; k <= W; k++) begin
      #3;
      chk("w2_stall_wait", b2.stall, 1);
      chk("w2_dmv_wait", b2.dm_valid, 0);
      chk("w2_coll", b2.collision, (k == 1) && wr && rd);
      @(posedge clk); #1;
    end
    #3;
    chk("w2_stall_resp", b2.stall, 0);
    chk("w2_dmv_resp", b2.dm_valid, rd && !wr);
    chk("w2_dm", b2.dm, dm2);
    chk("w2_coll_resp", b2.collision, 0);
    chk("w2_req_err", b2.req_err, err2);
    @(posedge clk); #1;
  endtask

  // One full access on the W=0 instance.
  task automatic acc0(input bit wr, input bit rd,
                      input logic [3:0] a, input logic [3:0] d);
    b0.wr_req  = wr;
    b0.rd_req  = rd;
    b0.addr    = a;
    b0.wr_data = d;
    #3;
    chk("w0_stall_req", b0.stall, 1);
    chk("w0_dmv_req", b0.dm_valid, 0);
    @(posedge clk); #1;
    b0.wr_req  = 1'b0;
    b0.rd_req  = 1'b0;
    b0.addr    = 4'($urandom);
    b0.wr_data = 4'($urandom);
    if (wr) m0[a] = d;
    else    dm0 = m0[a];
    #3;
    chk("w0_stall_resp", b0.stall, 0);
    chk("w0_dmv_resp", b0.dm_valid, rd && !wr);
    chk("w0_dm", b0.dm, dm0);
    chk("w0_coll", b0.collision, wr && rd);
    chk("w0_req_err", b0.req_err, err0);
    @(posedge clk); #1;
  endtask

  initial begin
    int op;
    logic [3:0] ra, rdat;
    b2.wr_req = 0; b2.rd_req = 0; b2.addr = 0; b2.wr_data = 0;
    b0.wr_req = 0; b0.rd_req = 0; b0.addr = 0; b0.wr_data = 0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm", b2.dm, 0);
    chk("rst_dmv", b2.dm_valid, 0);
    chk("rst_stall", b2.stall, 0);
    chk("rst_coll", b2.collision, 0);
    chk("rst_err", b2.req_err, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    acc2(1, 0, 4'd3, 4'hA);
    acc2(0, 1, 4'd3, 4'h0);

    acc2(1, 0, 4'd15, 4'h7);
    acc2(1, 0, 4'd0, 4'h1);
    acc2(0, 1, 4'd15, 4'h0);
    acc2(0, 1, 4'd0, 4'h0);
    acc2(0, 1, 4'd14, 4'h0);
    acc2(0, 1, 4'd1, 4'h0);

    acc2(1, 1, 4'd2, 4'hC);
    acc2(0, 1, 4'd2, 4'h0);

    acc0(1, 0, 4'd15, 4'h5);
    acc0(0, 1, 4'd15, 4'h0);
    acc0(1, 1, 4'd6, 4'h3);
    acc0(0, 1, 4'd6, 4'h0);

    repeat (40) begin
      op   = int'($urandom_range(0, 2));
      ra   = 4'($urandom);
      rdat = 4'($urandom);
      acc2(op != 1, op != 0, ra, rdat);
      op   = int'($urandom_range(0, 2));
      ra   = 4'($urandom);
      rdat = 4'($urandom);
      acc0(op != 1, op != 0, ra, rdat);
    end

    acc2(1, 0, 4'd8, 4'hF);
    acc2(0, 1, 4'd8, 4'h0);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_dm", b2.dm, 0);
    chk("mid_rst_dmv", b2.dm_valid, 0);
    chk("mid_rst_stall", b2.stall, 0);
    chk("mid_rst_err", b2.req_err, 0);
    chk("mid_rst_dm0", b0.dm, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      acc2(0, 1, 4'(i), 4'h0);
    end
    acc0(0, 1, 4'd6, 4'h0);

    b2.wr_req  = 1'b1;
    b2.addr    = 4'd5;
    b2.wr_data = 4'h6;
    #3;
    chk("err_stall_req", b2.stall, 1);
    @(posedge clk); #1;
    b2.wr_req  = 1'b0;
    b2.rd_req  = 1'b1;
    b2.addr    = 4'd9;
    b2.wr_data = 4'hE;
    #3;
    chk("err_stall_w1", b2.stall, 1);
    @(posedge clk); #1;
    b2.rd_req = 1'b0;
    #3;
    chk("err_set", b2.req_err, 1);
    chk("err_stall_w2", b2.stall, 1);
    @(posedge clk); #1;
    #3;
    chk("err_stall_resp", b2.stall, 0);
    chk("err_dmv_resp", b2.dm_valid, 0);
    chk("err_sticky", b2.req_err, 1);
    @(posedge clk); #1;
    m2[5] = 4'h6;
    err2  = 1'b1;
    acc2(0, 1, 4'd9, 4'h0);
    acc2(0, 1, 4'd5, 4'h0);

    acc2(1, 0, 4'd4, 4'h3);
    b2.wr_req  = 1'b1;
    b2.addr    = 4'd4;
    b2.wr_data = 4'h9;
    #3;
    @(posedge clk); #1;
    b2.wr_req = 1'b0;
    #1;
    chk("wait_stall", b2.stall, 1);
    reset_n = 1'b0;
    #1;
    chk("async_stall", b2.stall, 0);
    chk("async_err", b2.req_err, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    acc2(0, 1, 4'd4, 4'h0);
    acc2(0, 1, 4'd5, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
